minterm_scanner: RTL

MINTERM_SCANNER -- requirements
Module: minterm_scanner

---
 rtl/minterm_pkg.sv | 19 +
 rtl/minterm_check.sv | 44 ++++
 rtl/minterm_scanner.sv | 124 ++++++++++++
 3 files changed

// File: rtl/minterm_pkg.sv
// Shared definitions for the minterm scanner: FSM encoding and the
// vector, table and counter widths used by the scanner and its checker.
package minterm_pkg;

  localparam int VEC_W    = 4;
  localparam int TBL_W    = 1 << VEC_W;
  localparam int CNT_W    = $clog2(TBL_W) + 1;
  localparam int SETTLE_W = 4;

  localparam logic [VEC_W-1:0] VEC_LAST = {VEC_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/minterm_check.sv
// Per-sample comparator: counts captured values that differ from the golden
// table and latches the index of the first one.
module minterm_check
  import minterm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             sample_i,
  input  logic [VEC_W-1:0] idx_i,
  input  logic             f_i,
  input  logic             expected_i,
  output logic [CNT_W-1:0] mismatch_cnt_o,
  output logic [VEC_W-1:0] first_fail_o
);

  logic             diff;
  logic [CNT_W-1:0] mismatch_cnt_q;
  logic [VEC_W-1:0] first_fail_q;

  assign diff = sample_i && (f_i != expected_i);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_cnt_q <= '0;
      first_fail_q   <= '0;
    end else if (clear_i) begin
      mismatch_cnt_q <= '0;
      first_fail_q   <= '0;
    end else if (diff) begin
      mismatch_cnt_q <= mismatch_cnt_q + 1'b1;
      // A zero count before this increment means this is the first difference.
      if (mismatch_cnt_q == '0) begin
        first_fail_q <= idx_i;
      end
    end
  end

  assign mismatch_cnt_o = mismatch_cnt_q;
  assign first_fail_o   = first_fail_q;

endmodule

// File: rtl/minterm_scanner.sv
// Walks all 16 input vectors of a 4-input function block, captures f for each
// vector and grades the captured truth table against a golden table.
module minterm_scanner
  import minterm_pkg::*;
#(
  parameter int unsigned      SETTLE   = 1,
  parameter logic [TBL_W-1:0] EXPECTED = 16'hAA25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             f,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             busy,
  output logic             done,
  output logic [TBL_W-1:0] truth_table,
  output logic             match,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [VEC_W-1:0] first_fail
);

  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE - 1);

  state_e              state_q;
  logic [VEC_W-1:0]    idx_q;
  logic [SETTLE_W-1:0] settle_q;
  logic                busy_q;
  logic                done_q;
  logic                match_q;
  logic [TBL_W-1:0]    truth_table_q;
  logic [TBL_W-1:0]    truth_table_d;

  logic start_accept;
  logic sample_en;

  assign start_accept = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start && !abort;
  assign sample_en    = (state_q == ST_SAMPLE) && !abort;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    truth_table_d        = truth_table_q;
    truth_table_d[idx_q] = f;
  end

  // idx_q doubles as the stimulus register: it is 0 in IDLE, tracks the
  // vector in DRIVE/SAMPLE and is parked at 4'b1111 in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      settle_q      <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      match_q       <= 1'b0;
      truth_table_q <= '0;
    end else if (abort) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      settle_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      match_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q       <= ST_DRIVE;
            idx_q         <= '0;
            settle_q      <= '0;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            match_q       <= 1'b0;
            truth_table_q <= '0;
          end
        end
        ST_DRIVE: begin
          if (settle_q == SETTLE_LAST) begin
            state_q  <= ST_SAMPLE;
            settle_q <= '0;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        ST_SAMPLE: begin
          truth_table_q <= truth_table_d;
          if (idx_q == VEC_LAST) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            match_q <= (truth_table_d == EXPECTED);
          end else begin
            state_q <= ST_DRIVE;
            idx_q   <= idx_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  minterm_check u_check (
    .clk            (clk),
    .rst_n          (rst_n),
    .clear_i        (start_accept),
    .sample_i       (sample_en),
    .idx_i          (idx_q),
    .f_i            (f),
    .expected_i     (EXPECTED[idx_q]),
    .mismatch_cnt_o (mismatch_cnt),
    .first_fail_o   (first_fail)
  );

  assign {a, b, c, d}  = idx_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign match       = match_q;
  assign truth_table = truth_table_q;

endmodule
